axi_req_arbiter: RTL and testbench
==================================

Name: axi_req_arbiter

Overview:
- Shares the single AXI-Lite master FSM between N_REQ requesters (default: 0 = core load/store unit, 1 = UART program loader).
- Round-robin grant; registers address, write data and strobe for the master; drives the FSM's re/we control.
- Retries failed writes; turns read timeout into an error response.
- Sits between the memory-access requesters and the AXI FSM / AXI address-data mux.

Parameters:
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WR_RETRY, 3, write re-issues after a failed B response before reporting error

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  N_REQ  request per requester; held until its resp_valid
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_W  packed request addresses
- req_wdata  in  N_REQ*DATA_W  packed write data
- req_wstrb  in  N_REQ*(DATA_W/8)  packed byte strobes
- resp_valid  out  N_REQ  one-cycle completion pulse per requester
- resp_err  out  N_REQ  error qualifier, valid with resp_valid
- resp_rdata  out  DATA_W  read data broadcast to all; qualified by resp_valid
- fsm_re  out  1  read enable to AXI FSM
- fsm_we  out  1  write enable to AXI FSM
- fsm_r_success  in  1  read completed OK (combinational pulse)
- fsm_r_timeout  in  1  read error-count threshold reached
- fsm_w_success  in  1  write completed OK (one-cycle pulse)
- fsm_w_busy  in  1  write channel not idle
- m_addr  out  ADDR_W  registered address to AXI mux
- m_wdata  out  DATA_W  registered write data
- m_wstrb  out  DATA_W/8  registered strobes
- m_rdata  in  DATA_W  AXI read data, valid with fsm_r_success

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; rr pointer = 0; retry count = 0.
  - All outputs 0, including m_addr, m_wdata, m_wstrb and resp_rdata.
- State IDLE:
  - If any req_valid is set, pick the first set bit at or after the pointer (wrapping modulo N_REQ).
  - Latch the winner index, m_addr, m_wdata and m_wstrb.
  - Go to RD_WAIT or WR_ISSUE. Grant is taken on the edge after req_valid is seen.
- State RD_WAIT:
  - fsm_re = 1 && !tout_rise, where tout_rise = fsm_r_timeout && !fsm_r_timeout_q (combinational, so the FSM stays idle).
  - fsm_re stays high across FSM slave-error retries.
  - fsm_r_success: capture m_rdata into resp_rdata, err = 0, go to RESP.
  - tout_rise: err = 1, go to RESP.
- State WR_ISSUE: fsm_we = 1 for exactly one cycle, then WR_WAIT. fsm_we is never held.
- State WR_WAIT:
  - fsm_w_success: err = 0, go to RESP.
  - fsm_w_busy = 0 without fsm_w_success means a B error.
    - If retry count < WR_RETRY: increment it and go to WR_ISSUE.
    - Otherwise: err = 1, go to RESP.
- State RESP:
  - resp_valid[winner] = 1 and resp_err[winner] = err for one cycle.
  - pointer = winner+1 mod N_REQ; retry count = 0; go to IDLE.
- Grant rules:
  - Only one transaction in flight.
  - req_valid changes after grant are ignored until RESP.
  - A requester dropping req_valid early still receives its response.
- Minimum turnaround: IDLE→RD_WAIT→RESP→IDLE; resp_valid arrives no earlier than the cycle after fsm_r_success.
- Simultaneous requests: the pointer decides, so consecutive grants alternate between continuous requesters.
- resp_rdata holds its last captured value; it is not updated on writes or errors.
- Reset mid-transaction: abort with no response. The FSM is reset by the same reset, inverted externally.

Optional Feature:
- Macro: AXI_ARB_STATS_EN.
- Defined: adds output stat_rd_cnt, stat_wr_cnt and stat_err_cnt, each 32 bits.
  - Rd/wr counters increment in RESP when err = 0; the error counter increments when err = 1. All saturate.
  - Also adds stat_retry_cnt (16 bits), incremented per write re-issue.
  - All counters reset to 0.
- Undefined: no ports, no counters; core behaviour identical.

Decomposition:
- Package axi_arb_pkg: arbiter state enum (IDLE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP) and default ADDR_W/DATA_W constants.
- Sub-module axi_rr_pick: combinational round-robin picker (req vector, pointer → one-hot grant + index). Reusable by other shared-resource arbiters.

Test Plan:
- Req0 read 0x0000_1000; FSM pulses r_success with m_rdata=0xDEAD_BEEF 3 cycles later → resp_valid[0] one cycle later, resp_err=0, resp_rdata=0xDEAD_BEEF; fsm_re deasserts the same cycle.
- Req0 and req1 assert together from reset, both continuously → grants 0,1,0,1; each resp_valid pulses once per grant.
- Write 0x55 to 0x20, strb=0001; first attempt w_busy falls without w_success, second attempt succeeds → fsm_we pulses exactly twice, resp_err=0.
- Write with B errors on 4 consecutive attempts (WR_RETRY=3) → 4 fsm_we pulses, then resp_err=1.
- Read where fsm_r_timeout rises → fsm_re=0 in that cycle; resp_err=1; resp_rdata unchanged.
- rst_n pulsed low while in WR_WAIT → outputs 0 immediately; no resp_valid; the next request is granted normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and default widths for the AXI-Lite request arbiter.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    WR_ISSUE = 3'd2,
    WR_WAIT  = 3'd3,
    RESP     = 3'd4
  } arb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module axi_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/axi_req_arbiter.sv
// Round-robin sharing of one AXI-Lite master FSM between N_REQ requesters.
// Optional statistics counters are enabled with `define AXI_ARB_STATS_EN.
module axi_req_arbiter
  import axi_arb_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WR_RETRY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_we,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]           resp_valid,
  output logic [N_REQ-1:0]           resp_err,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       fsm_re,
  output logic                       fsm_we,
  input  logic                       fsm_r_success,
  input  logic                       fsm_r_timeout,
  input  logic                       fsm_w_success,
  input  logic                       fsm_w_busy,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic [DATA_W-1:0]          m_rdata
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [31:0]                stat_rd_cnt,
  output logic [31:0]                stat_wr_cnt,
  output logic [31:0]                stat_err_cnt,
  output logic [15:0]                stat_retry_cnt
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RTY_W  = (WR_RETRY > 0) ? $clog2(WR_RETRY + 1) : 1;
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(WR_RETRY);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  arb_state_e       state, state_d;
  logic [IDX_W-1:0] ptr, winner, pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_any;
  logic             winner_we;
  logic [RTY_W-1:0] retry_cnt;
  logic             err, err_d;
  logic             tout_q, tout_rise;
  logic             take, rd_cap, rty_inc, done;

  axi_rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the first cycle of a timeout level counts; the master stays idle that cycle.
  assign tout_rise = fsm_r_timeout && !tout_q;

  always_comb begin
    state_d    = state;
    err_d      = err;
    take       = 1'b0;
    rd_cap     = 1'b0;
    rty_inc    = 1'b0;
    done       = 1'b0;
    fsm_re     = 1'b0;
    fsm_we     = 1'b0;
    resp_valid = '0;
    resp_err   = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          take    = 1'b1;
          state_d = req_we[pick_idx] ? WR_ISSUE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        fsm_re = !tout_rise;
        if (fsm_r_success) begin
          rd_cap  = 1'b1;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tout_rise) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WR_ISSUE: begin
        fsm_we  = 1'b1;
        state_d = WR_WAIT;
      end
      WR_WAIT: begin
        if (fsm_w_success) begin
          err_d   = 1'b0;
          state_d = RESP;
        end else if (!fsm_w_busy) begin
          // Channel went idle without success: the B response was an error.
          if (retry_cnt < RTY_MAX) begin
            rty_inc = 1'b1;
            state_d = WR_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        resp_valid[winner] = 1'b1;
        resp_err[winner]   = err;
        done               = 1'b1;
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      winner    <= '0;
      winner_we <= 1'b0;
      retry_cnt <= '0;
      err       <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      tout_q <= fsm_r_timeout;
      err    <= err_d;
      if (take) begin
        winner    <= pick_idx;
        winner_we <= req_we[pick_idx];
      end
      if (rty_inc) retry_cnt <= retry_cnt + RTY_W'(1);
      if (done) begin
        retry_cnt <= '0;
        ptr       <= (winner == IDX_LAST) ? '0 : winner + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      resp_rdata <= '0;
    end else begin
      if (take) begin
        m_addr  <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        m_wdata <= req_wdata[pick_idx*DATA_W +: DATA_W];
        m_wstrb <= req_wstrb[pick_idx*STRB_W +: STRB_W];
      end
      if (rd_cap) resp_rdata <= m_rdata;
    end
  end

`ifdef AXI_ARB_STATS_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_err_cnt   <= '0;
      stat_retry_cnt <= '0;
    end else begin
      if (done) begin
        if (err)            stat_err_cnt <= sat_inc32(stat_err_cnt);
        else if (winner_we) stat_wr_cnt  <= sat_inc32(stat_wr_cnt);
        else                stat_rd_cnt  <= sat_inc32(stat_rd_cnt);
      end
      if (rty_inc) stat_retry_cnt <= sat_inc16(stat_retry_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Scoreboard bench for axi_req_arbiter with a scripted AXI FSM write-side model.
module tb_axi_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_we = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N*DW-1:0]   req_wdata = '0;
  logic [N*SW-1:0]   req_wstrb = '0;
  logic [N-1:0]      resp_valid, resp_err;
  logic [DW-1:0]     resp_rdata;
  logic              fsm_re, fsm_we;
  logic              fsm_r_success = 1'b0;
  logic              fsm_r_timeout = 1'b0;
  logic              fsm_w_success = 1'b0;
  logic              fsm_w_busy = 1'b0;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic [SW-1:0]     m_wstrb;
  logic [DW-1:0]     m_rdata = '0;
`ifdef AXI_ARB_STATS_EN
  logic [31:0]       stat_rd_cnt, stat_wr_cnt, stat_err_cnt;
  logic [15:0]       stat_retry_cnt;
`endif

  axi_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WR_RETRY(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .resp_valid    (resp_valid),
    .resp_err      (resp_err),
    .resp_rdata    (resp_rdata),
    .fsm_re        (fsm_re),
    .fsm_we        (fsm_we),
    .fsm_r_success (fsm_r_success),
    .fsm_r_timeout (fsm_r_timeout),
    .fsm_w_success (fsm_w_success),
    .fsm_w_busy    (fsm_w_busy),
    .m_addr        (m_addr),
    .m_wdata       (m_wdata),
    .m_wstrb       (m_wstrb),
    .m_rdata       (m_rdata)
`ifdef AXI_ARB_STATS_EN
    ,
    .stat_rd_cnt   (stat_rd_cnt),
    .stat_wr_cnt   (stat_wr_cnt),
    .stat_err_cnt  (stat_err_cnt),
    .stat_retry_cnt(stat_retry_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Write-side FSM model: busy follows each fsm_we pulse for two cycles,
  // then ends with either a B error (fail_left > 0) or a success pulse.
  int we_pulses = 0;
  int fail_left = 0;
  int busy_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no DUT event within cycle budget", name);
  endtask

  always @(negedge clk) begin : wr_model
    if (!rst_n) begin
      fsm_w_busy    = 1'b0;
      fsm_w_success = 1'b0;
      busy_cyc      = 0;
    end else if (fsm_we) begin
      we_pulses++;
      fsm_w_busy    = 1'b1;
      fsm_w_success = 1'b0;
      busy_cyc      = 0;
    end else if (fsm_w_busy) begin
      busy_cyc++;
      if (busy_cyc == 2) begin
        fsm_w_busy = 1'b0;
        if (fail_left > 0) fail_left--;
        else fsm_w_success = 1'b1;
      end
    end else begin
      fsm_w_success = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [N-1:0] vec;
    if (rst_n && resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp_valid", 64'(resp_valid), 64'd0);
      end else begin
        e   = exp_q.pop_front();
        vec = '0;
        vec[e.idx] = 1'b1;
        check("resp_valid", 64'(resp_valid), 64'(vec));
        check("resp_err", 64'(resp_err), e.err ? 64'(vec) : 64'd0);
        check("resp_rdata", 64'(resp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic push_exp(input int idx, input bit err, input logic [31:0] rd);
    exp_t e;
    e.idx = idx; e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_re(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fsm_re) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("wait_fsm_re");
  endtask

  task automatic wait_we(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (fsm_we) begin ok = 1'b1; break; end
    end
    if (!ok) timeout_fail("wait_fsm_we");
  endtask

  // Pulse r_success `delay` cycles after the first fsm_re cycle; returns in RESP.
  task automatic rd_done(input logic [31:0] d, input int delay);
    repeat (delay) @(negedge clk);
    fsm_r_success = 1'b1;
    m_rdata       = d;
    @(negedge clk);
    fsm_r_success = 1'b0;
    m_rdata       = 32'h0BAD_0BAD;
  endtask

  task automatic wait_resp_drop(input int i);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (resp_valid[i]) begin seen = 1'b1; req_valid[i] = 1'b0; break; end
    end
    if (!seen) timeout_fail("wait_resp_valid");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    bit ok;
    logic [31:0] last_rd;

    // Reset state
    @(negedge clk);
    check("rst_fsm_re", 64'(fsm_re), 64'd0);
    check("rst_fsm_we", 64'(fsm_we), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_m_wdata", 64'(m_wdata), 64'd0);
    check("rst_m_wstrb", 64'(m_wstrb), 64'd0);
    check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0, success 3 cycles into RD_WAIT
    set_req(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    push_exp(0, 1'b0, 32'hDEAD_BEEF);
    wait_re(ok);
    check("t1_m_addr", 64'(m_addr), 64'h1000);
    rd_done(32'hDEAD_BEEF, 2);
    check("t1_fsm_re_low_in_resp", 64'(fsm_re), 64'd0);
    check("t1_resp_valid_now", 64'(resp_valid), 64'd1);
    req_valid[0] = 1'b0;

    // Two continuous readers from reset: grants alternate 0,1,0,1
    @(negedge clk);
    do_reset();
    set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      push_exp(k % 2, 1'b0, 32'hA000_0000 + 32'(k));
      wait_re(ok);
      check("t2_m_addr", 64'(m_addr), (k % 2 == 1) ? 64'h200 : 64'h100);
      rd_done(32'hA000_0000 + 32'(k), 1);
      if (k == 3) req_valid = '0;
    end
    last_rd = 32'hA000_0003;

    // Write with one B error then success (pointer now at 0)
    @(negedge clk);
    we_pulses = 0;
    fail_left = 1;
    set_req(0, 1'b1, 32'h0000_0020, 32'h0000_0055, 4'b0001);
    push_exp(0, 1'b0, last_rd);
    wait_we(ok);
    check("t3_m_addr", 64'(m_addr), 64'h20);
    check("t3_m_wdata", 64'(m_wdata), 64'h55);
    check("t3_m_wstrb", 64'(m_wstrb), 64'h1);
    wait_resp_drop(0);
    check("t3_we_pulses", 64'(we_pulses), 64'd2);

    // Write from requester 1 with four consecutive B errors
    @(negedge clk);
    we_pulses = 0;
    fail_left = 4;
    set_req(1, 1'b1, 32'h0000_0030, 32'h1234_5678, 4'b1111);
    push_exp(1, 1'b1, last_rd);
    wait_resp_drop(1);
    check("t4_we_pulses", 64'(we_pulses), 64'd4);
    fail_left = 0;

    // Read from requester 0 ending in a timeout rise
    @(negedge clk);
    set_req(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0);
    push_exp(0, 1'b1, last_rd);
    wait_re(ok);
    fsm_r_timeout = 1'b1;
    #1;
    check("t5_fsm_re_on_tout_rise", 64'(fsm_re), 64'd0);
    @(negedge clk);
    check("t5_fsm_re_in_resp", 64'(fsm_re), 64'd0);
    req_valid[0]  = 1'b0;
    fsm_r_timeout = 1'b0;

    // Reset while requester 1 waits in WR_WAIT
    @(negedge clk);
    we_pulses = 0;
    set_req(1, 1'b1, 32'h0000_0040, 32'h0000_00AA, 4'hF);
    wait_we(ok);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_fsm_we", 64'(fsm_we), 64'd0);
    check("t6_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("t6_rst_m_addr", 64'(m_addr), 64'd0);
    check("t6_rst_m_wdata", 64'(m_wdata), 64'd0);
    check("t6_rst_resp_rdata", 64'(resp_rdata), 64'd0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
    push_exp(1, 1'b0, 32'h1234_5678);
    wait_re(ok);
    check("t6_post_rst_m_addr", 64'(m_addr), 64'h50);
    rd_done(32'h1234_5678, 1);
    req_valid[1] = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
